// File: rtl/wb_sched_if.sv
// Writeback scheduler bus: pipeline request, load return and register-file write side.
// Master drives requests; slave is the scheduler.
interface wb_sched_if;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic [1:0]  wb_src_i;
    logic [31:0] wb_alu_i;
    logic [31:0] wb_pc_i;
    logic [31:0] wb_pctarget_i;
    logic        wb_ready_o;

    logic        ld_valid_i;
    logic [4:0]  ld_rd_i;
    logic [31:0] ld_data_i;
    logic        ld_ready_o;

    logic        RegWrite_o;
    logic [4:0]  Rd_o;
    logic [1:0]  ResultSrc_o;
    logic [31:0] ALU_o;
    logic [31:0] Mem_o;
    logic [31:0] PC_o;
    logic [31:0] PCtarget_o;
    logic        err_o;

    modport master (
        output wb_valid_i, wb_rd_i, wb_src_i, wb_alu_i, wb_pc_i, wb_pctarget_i,
        output ld_valid_i, ld_rd_i, ld_data_i,
        input  wb_ready_o, ld_ready_o,
        input  RegWrite_o, Rd_o, ResultSrc_o, ALU_o, Mem_o, PC_o, PCtarget_o, err_o
    );

    modport slave (
        input  wb_valid_i, wb_rd_i, wb_src_i, wb_alu_i, wb_pc_i, wb_pctarget_i,
        input  ld_valid_i, ld_rd_i, ld_data_i,
        output wb_ready_o, ld_ready_o,
        output RegWrite_o, Rd_o, ResultSrc_o, ALU_o, Mem_o, PC_o, PCtarget_o, err_o
    );
endinterface

// File: rtl/wb_sched.sv
// Writeback scheduler: shares the register-file write port between pipeline results and a
// load-return queue. Define WB_SCHED_BYPASS_EN to let a load skip an empty queue.
module wb_sched #(
    parameter int unsigned LQ_DEPTH = 4,
    parameter int unsigned MAX_WAIT = 3
) (
    input logic        clk,
    input logic        rst,
    wb_sched_if.slave  bus
);
    localparam int unsigned PtrW  = $clog2(LQ_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] MaxWait = WaitW'(MAX_WAIT);
    localparam logic [CntW-1:0]  Depth   = CntW'(LQ_DEPTH);

    logic [4:0]      lq_rd_q   [LQ_DEPTH];
    logic [31:0]     lq_data_q [LQ_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

    logic        lq_empty, ld_ready, push, pop;
    logic        cand_valid, grant_ld, grant_wb;
    logic [4:0]  cand_rd;
    logic [31:0] cand_data;

    logic        regwrite_q, err_q;
    logic [4:0]  rd_q;
    logic [1:0]  result_src_q;
    logic [31:0] alu_q, mem_q, pc_q, pctarget_q;

    always_comb begin
        lq_empty = (count_q == '0);
        ld_ready = (count_q < Depth);
`ifdef WB_SCHED_BYPASS_EN
        // An empty queue lets the incoming load compete directly for this cycle's slot.
        cand_valid = !lq_empty || bus.ld_valid_i;
        cand_rd    = lq_empty ? bus.ld_rd_i   : lq_rd_q[rd_ptr_q];
        cand_data  = lq_empty ? bus.ld_data_i : lq_data_q[rd_ptr_q];
`else
        cand_valid = !lq_empty;
        cand_rd    = lq_rd_q[rd_ptr_q];
        cand_data  = lq_data_q[rd_ptr_q];
`endif
        grant_ld = cand_valid && (!bus.wb_valid_i || (wait_cnt_q < MaxWait));
        grant_wb = bus.wb_valid_i && !grant_ld;
`ifdef WB_SCHED_BYPASS_EN
        push = bus.ld_valid_i && ld_ready && !(lq_empty && grant_ld);
        pop  = grant_ld && !lq_empty;
`else
        push = bus.ld_valid_i && ld_ready;
        pop  = grant_ld;
`endif
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        wait_cnt_d = wait_cnt_q;
        if (grant_wb || !bus.wb_valid_i) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MaxWait) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q    <= count_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Queue storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd_q[wr_ptr_q]   <= bus.ld_rd_i;
            lq_data_q[wr_ptr_q] <= bus.ld_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q   <= 1'b0;
            err_q        <= 1'b0;
            rd_q         <= '0;
            result_src_q <= '0;
            alu_q        <= '0;
            mem_q        <= '0;
            pc_q         <= '0;
            pctarget_q   <= '0;
        end else begin
            regwrite_q <= 1'b0;
            err_q      <= 1'b0;
            if (grant_ld) begin
                regwrite_q   <= (cand_rd != 5'd0);
                rd_q         <= cand_rd;
                result_src_q <= 2'd1;
                mem_q        <= cand_data;
            end else if (grant_wb) begin
                if (bus.wb_src_i == 2'd1) begin
                    result_src_q <= 2'd0;
                    err_q        <= 1'b1;
                end else begin
                    regwrite_q   <= (bus.wb_rd_i != 5'd0);
                    rd_q         <= bus.wb_rd_i;
                    result_src_q <= bus.wb_src_i;
                    alu_q        <= bus.wb_alu_i;
                    pc_q         <= bus.wb_pc_i;
                    pctarget_q   <= bus.wb_pctarget_i;
                end
            end
        end
    end

    assign bus.wb_ready_o  = grant_wb;
    assign bus.ld_ready_o  = ld_ready;
    assign bus.RegWrite_o  = regwrite_q;
    assign bus.Rd_o        = rd_q;
    assign bus.ResultSrc_o = result_src_q;
    assign bus.ALU_o       = alu_q;
    assign bus.Mem_o       = mem_q;
    assign bus.PC_o        = pc_q;
    assign bus.PCtarget_o  = pctarget_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_wb_sched.sv
// Directed self-checking bench for wb_sched (LQ_DEPTH=4, MAX_WAIT=3).
module tb_wb_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   n;

    wb_sched_if bus ();

    wb_sched #(.LQ_DEPTH(4), .MAX_WAIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a pipeline request and push one load per cycle until the queue reports full.
    task automatic fill_queue(output int pushed);
        pushed = 0;
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = 5'd3;
        bus.wb_src_i   = 2'd0;
        bus.wb_alu_i   = 32'hA5A5;
        for (int i = 0; i < 40; i++) begin
            bus.ld_valid_i = 1'b1;
            bus.ld_rd_i    = 5'(10 + pushed);
            bus.ld_data_i  = 32'h1000 + 32'(pushed);
            #1;
            if (!bus.ld_ready_o) break;
            pushed++;
            tick();
        end
        chk("lq_full_ready", 32'(bus.ld_ready_o), 0);
    endtask

    initial begin
        bus.wb_valid_i = 1'b0; bus.wb_rd_i = '0; bus.wb_src_i = '0;
        bus.wb_alu_i = '0; bus.wb_pc_i = '0; bus.wb_pctarget_i = '0;
        bus.ld_valid_i = 1'b0; bus.ld_rd_i = '0; bus.ld_data_i = '0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regwrite", 32'(bus.RegWrite_o), 0);
        chk("rst_rd", 32'(bus.Rd_o), 0);
        chk("rst_src", 32'(bus.ResultSrc_o), 0);
        chk("rst_alu", bus.ALU_o, 0);
        chk("rst_mem", bus.Mem_o, 0);
        chk("rst_pc", bus.PC_o, 0);
        chk("rst_pct", bus.PCtarget_o, 0);
        chk("rst_err", 32'(bus.err_o), 0);
        rst = 1'b0;
        #1;
        chk("idle_ld_ready", 32'(bus.ld_ready_o), 1);
        chk("idle_wb_ready", 32'(bus.wb_ready_o), 0);
        tick();
        chk("idle_regwrite", 32'(bus.RegWrite_o), 0);

        // Single pipeline write, PC-target source
        bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd5; bus.wb_src_i = 2'd3;
        bus.wb_alu_i = 32'h11; bus.wb_pc_i = 32'h22; bus.wb_pctarget_i = 32'h100;
        #1;
        chk("wb_ready", 32'(bus.wb_ready_o), 1);
        tick();
        bus.wb_valid_i = 1'b0;
        chk("wb_regwrite", 32'(bus.RegWrite_o), 1);
        chk("wb_rd", 32'(bus.Rd_o), 5);
        chk("wb_src", 32'(bus.ResultSrc_o), 3);
        chk("wb_pct", bus.PCtarget_o, 32'h100);
        chk("wb_alu", bus.ALU_o, 32'h11);
        chk("wb_pc", bus.PC_o, 32'h22);
        chk("wb_mem_hold", bus.Mem_o, 0);
        tick();
        chk("wb_regwrite_drop", 32'(bus.RegWrite_o), 0);
        chk("wb_rd_hold", 32'(bus.Rd_o), 5);

        // Single load through an empty queue
        bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'd7; bus.ld_data_i = 32'hDEADBEEF;
        #1;
        chk("ld_ready", 32'(bus.ld_ready_o), 1);
        tick();
        bus.ld_valid_i = 1'b0;
`ifndef WB_SCHED_BYPASS_EN
        chk("ld_lat_early", 32'(bus.RegWrite_o), 0);
        tick();
`endif
        chk("ld_regwrite", 32'(bus.RegWrite_o), 1);
        chk("ld_src", 32'(bus.ResultSrc_o), 1);
        chk("ld_mem", bus.Mem_o, 32'hDEADBEEF);
        chk("ld_rd", 32'(bus.Rd_o), 7);
        chk("ld_pct_hold", bus.PCtarget_o, 32'h100);
        tick();
        chk("ld_regwrite_drop", 32'(bus.RegWrite_o), 0);

        // Fill to 4 entries under pipeline pressure, then drain: 3 loads, wb, last load
        fill_queue(n);
        chk("full_wb_ready", 32'(bus.wb_ready_o), 0);
        tick();
        bus.ld_valid_i = 1'b0;
        chk("drain0_rd", 32'(bus.Rd_o), 32'(10 + n - 4));
        chk("drain0_mem", bus.Mem_o, 32'h1000 + 32'(n - 4));
        #1;
        chk("drain1_wb_ready", 32'(bus.wb_ready_o), 0);
        tick();
        chk("drain1_rd", 32'(bus.Rd_o), 32'(10 + n - 3));
        chk("drain2_wb_ready", 32'(bus.wb_ready_o), 0);
        tick();
        chk("drain2_rd", 32'(bus.Rd_o), 32'(10 + n - 2));
        chk("drain3_wb_ready", 32'(bus.wb_ready_o), 1);
        tick();
        chk("drain3_rd", 32'(bus.Rd_o), 3);
        chk("drain3_src", 32'(bus.ResultSrc_o), 0);
        chk("drain3_alu", bus.ALU_o, 32'hA5A5);
        chk("drain4_wb_ready", 32'(bus.wb_ready_o), 0);
        tick();
        chk("drain4_rd", 32'(bus.Rd_o), 32'(10 + n - 1));
        chk("drain4_src", 32'(bus.ResultSrc_o), 1);
        chk("empty_wb_ready", 32'(bus.wb_ready_o), 1);
        tick();
        bus.wb_valid_i = 1'b0;
        chk("empty_rd", 32'(bus.Rd_o), 3);
        tick();

        // Illegal source select
        bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd9; bus.wb_src_i = 2'd1; bus.wb_alu_i = 32'h99;
        #1;
        chk("ill_ready", 32'(bus.wb_ready_o), 1);
        tick();
        bus.wb_valid_i = 1'b0;
        chk("ill_regwrite", 32'(bus.RegWrite_o), 0);
        chk("ill_err", 32'(bus.err_o), 1);
        chk("ill_src", 32'(bus.ResultSrc_o), 0);
        chk("ill_alu_hold", bus.ALU_o, 32'hA5A5);
        tick();
        chk("ill_err_pulse", 32'(bus.err_o), 0);

        // Writes to x0 consume a slot without a register-file write
        bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'd0; bus.ld_data_i = 32'h55;
        tick();
        bus.ld_valid_i = 1'b0;
`ifndef WB_SCHED_BYPASS_EN
        tick();
`endif
        chk("x0_ld_regwrite", 32'(bus.RegWrite_o), 0);
        chk("x0_ld_mem", bus.Mem_o, 32'h55);
        chk("x0_ld_src", 32'(bus.ResultSrc_o), 1);
        bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd0; bus.wb_src_i = 2'd0; bus.wb_alu_i = 32'h77;
        #1;
        chk("x0_wb_ready", 32'(bus.wb_ready_o), 1);
        tick();
        bus.wb_valid_i = 1'b0;
        chk("x0_wb_regwrite", 32'(bus.RegWrite_o), 0);
        chk("x0_wb_alu", bus.ALU_o, 32'h77);
        chk("x0_wb_src", 32'(bus.ResultSrc_o), 0);
        tick();

        // Reset with 3 queued loads discards them
        fill_queue(n);
        tick();
        bus.ld_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        chk("mrst_regwrite", 32'(bus.RegWrite_o), 0);
        chk("mrst_mem", bus.Mem_o, 0);
        chk("mrst_rd", 32'(bus.Rd_o), 0);
        rst = 1'b0;
        #1;
        chk("mrst_wb_ready", 32'(bus.wb_ready_o), 1);
        chk("mrst_ld_ready", 32'(bus.ld_ready_o), 1);
        tick();
        bus.wb_valid_i = 1'b0;
        chk("mrst_wb_rd", 32'(bus.Rd_o), 3);
        tick();
        chk("mrst_flush0", 32'(bus.RegWrite_o), 0);
        tick();
        chk("mrst_flush1", 32'(bus.RegWrite_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_sched.md
Name: wb_sched

Overview:
- Writeback scheduler that shares the single register-file write port between two requesters:
  - in-order pipeline writebacks (ALU, PC+4, PC-target results);
  - variable-latency data-memory load returns.
- Buffers load returns in a small queue and arbitrates between the queue and the pipeline, with starvation protection for the pipeline.
- Registers the winner into an output stage that drives the data inputs and ResultSrc select of the writeback result multiplexer, plus RegWrite/Rd to the register file.

Parameters:
- LQ_DEPTH, 4, load-queue entries; power of two, >= 2.
- MAX_WAIT, 3, consecutive lost cycles after which a pending pipeline request overrides load priority; >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- wb_valid_i  in  1  pipeline writeback request.
- wb_rd_i  in  5  pipeline destination register.
- wb_src_i  in  2  pipeline result select: 0 ALU, 2 PC, 3 PCtarget; 1 illegal.
- wb_alu_i  in  32  ALU result.
- wb_pc_i  in  32  PC+4 value.
- wb_pctarget_i  in  32  PC-target value.
- wb_ready_o  out  1  pipeline request accepted this cycle (combinational).
- ld_valid_i  in  1  load return valid.
- ld_rd_i  in  5  load destination register.
- ld_data_i  in  32  load data.
- ld_ready_o  out  1  load queue can accept (combinational).
- RegWrite_o  out  1  register-file write enable (registered).
- Rd_o  out  5  write destination (registered).
- ResultSrc_o  out  2  result mux select (registered).
- ALU_o, Mem_o, PC_o, PCtarget_o  out  32 each  result mux data inputs (registered).
- err_o  out  1  one-cycle pulse: illegal wb_src_i accepted (registered).

Behaviour:
- Reset:
  - All outputs 0; queue empty (wr_ptr, rd_ptr, count = 0); wait_cnt = 0.
  - Reset mid-operation discards queued loads and any in-flight grant.
- Load queue:
  - Circular FIFO; count width clog2(LQ_DEPTH)+1.
  - ld_ready_o = (count < LQ_DEPTH). No pass-through when full, even if popping the same cycle.
  - Push when ld_valid_i && ld_ready_o; pop when the head is granted.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo LQ_DEPTH.
- Arbitration (combinational, evaluated every cycle):
  - grant_ld = lq_nonempty && (!wb_valid_i || wait_cnt < MAX_WAIT).
  - grant_wb = wb_valid_i && !grant_ld.
  - wb_ready_o = grant_wb.
- wait_cnt:
  - Reset to 0 on grant_wb, or when !wb_valid_i.
  - Otherwise increment, saturating at MAX_WAIT.
  - Guarantees a pipeline request waits at most MAX_WAIT cycles.
- Output stage (next edge after grant; latency 1 from grant):
  - Load grant: RegWrite_o = (rd != 0); Rd_o = rd; ResultSrc_o = 1; Mem_o = data. ALU_o, PC_o and PCtarget_o hold.
  - Pipeline grant, legal src: RegWrite_o = (wb_rd_i != 0); Rd_o = wb_rd_i; ResultSrc_o = wb_src_i; ALU_o, PC_o, PCtarget_o captured; Mem_o holds.
  - Pipeline grant, src == 1: request consumed; RegWrite_o = 0; ResultSrc_o = 0; err_o = 1 for one cycle.
  - No grant: RegWrite_o = 0, err_o = 0; all other outputs hold.
- Writes to x0 consume a grant slot but never assert RegWrite_o.
- RAW ordering between queued loads and later pipeline writes to the same rd is the hazard unit's responsibility, not this block's.

Optional Feature:
- Macro: WB_SCHED_BYPASS_EN.
- Defined:
  - When count == 0 and ld_valid_i is high, the incoming load is the arbitration candidate that same cycle (lq_nonempty is treated as true).
  - If granted, it is not written into the queue; minimum load latency is 1 cycle.
  - If not granted, it is pushed normally.
- Undefined:
  - Every load passes through the queue; minimum load-in to RegWrite_o latency is 2 cycles.

Test Plan:
- Reset, then idle:
  - All outputs 0, ld_ready_o = 1, wb_ready_o = 0.
  - Assert rst mid-queue with 3 entries: count = 0 next cycle, RegWrite_o = 0.
- Single pipeline write, wb_src_i = 3, rd = 5, pctarget = 0x100 -> wb_ready_o = 1 same cycle; next cycle RegWrite_o = 1, Rd_o = 5, ResultSrc_o = 3, PCtarget_o = 0x100.
- Load rd = 7, data = 0xDEADBEEF, queue empty, no bypass -> 2 cycles later RegWrite_o = 1, ResultSrc_o = 1, Mem_o = 0xDEADBEEF.
  - With WB_SCHED_BYPASS_EN: 1 cycle later.
- Fill queue with 4 loads while wb_valid_i held high:
  - ld_ready_o = 0 at count = 4.
  - 3 load grants, then wb grant on the 4th cycle (MAX_WAIT = 3), then the remaining load.
- wb_src_i = 1, rd = 9 -> consumed; next cycle RegWrite_o = 0, err_o = 1.
- Load to rd = 0 and pipeline write to rd = 0 -> each granted; RegWrite_o stays 0.
